// File: rtl/pat_gen_seq.sv
// -----------------------------------------------------------------------------
// pat_gen_seq
// -----------------------------------------------------------------------------
// Pattern generator sequencer. Holds NUM_REGS pattern words that are written
// over a simple address/data port from the SI register bus. When enabled, it
// streams the first cfg_len_i words to a downstream consumer over a
// valid/ready handshake, either once or repeatedly.
//
// Optional build macro:
//   PAT_GEN_CHECKSUM_EN - adds pat_csum_o, a running XOR of every word the
//                         consumer accepted since the last start.
//
// Ports:
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous reset, active-high
//   ctl_pat_data_i  write data; only the low DATA_WIDTH bits are stored
//   si_addr_i       write word index
//   wr_en_i         write strobe, one write per cycle
//   wr_err_o        one-cycle pulse when a write was dropped
//   cfg_pat_gen_i   generator enable (level)
//   cfg_len_i       pattern length in words, 1..NUM_REGS
//   cfg_loop_i      1 = repeat pattern, 0 = one-shot
//   pat_data_o      registered pattern word
//   pat_valid_o     pattern word valid
//   pat_ready_i     consumer ready
//   done_o          one-cycle pulse on entry to DONE
//   nopg_o          1 = no pattern being generated
//   pat_csum_o      XOR checksum of accepted words (PAT_GEN_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module pat_gen_seq #(
   parameter int ADDR_WIDTH          = 32,
   parameter int DATA_WIDTH          = 12,
   parameter int NUM_REGS            = 21,
   parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
   localparam int IDX_W              = $clog2(NUM_REGS + 1)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_i,
   input  logic [ADDR_WIDTH-1:0]          si_addr_i,
   input  logic                           wr_en_i,
   output logic                           wr_err_o,
   input  logic                           cfg_pat_gen_i,
   input  logic [IDX_W-1:0]               cfg_len_i,
   input  logic                           cfg_loop_i,
   output logic [DATA_WIDTH-1:0]          pat_data_o,
   output logic                           pat_valid_o,
   input  logic                           pat_ready_i,
   output logic                           done_o,
   output logic                           nopg_o
`ifdef PAT_GEN_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]          pat_csum_o
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                state, state_next;
   logic [DATA_WIDTH-1:0] pat_regs [NUM_REGS];
   logic [IDX_W-1:0]      ptr, ptr_next;
   logic [IDX_W-1:0]      len_q, len_next;
   logic                  loop_q, loop_next;
   logic [DATA_WIDTH-1:0] data_next;
   logic                  addr_ok;
   logic                  wr_accept;
   logic                  wr_drop;
   logic                  beat;
   logic                  len_ok;
   logic                  last_word;
   logic                  starting;

   // Write qualification: the whole address is compared so that any set
   // upper bit rejects the write instead of aliasing onto a low register.
   // The pattern is frozen while streaming, so writes in RUN are dropped.
   assign addr_ok   = (si_addr_i < ADDR_WIDTH'(NUM_REGS));
   assign wr_accept = wr_en_i && addr_ok && (state != RUN);
   assign wr_drop   = wr_en_i && !wr_accept;

   // Handshake and sequencing helpers.
   assign beat      = pat_valid_o && pat_ready_i;
   assign len_ok    = (cfg_len_i != '0) && (cfg_len_i <= IDX_W'(NUM_REGS));
   assign last_word = (ptr == (len_q - IDX_W'(1)));
   assign starting  = (state == IDLE) && (state_next == RUN);

   // The write bus may be wider than a pattern word; the excess bits are
   // deliberately discarded.
   generate
      if (SUB_REGS_DATA_WIDTH > DATA_WIDTH) begin : g_unused_bits
         logic unused_wr_bits;
         assign unused_wr_bits = ^ctl_pat_data_i[SUB_REGS_DATA_WIDTH-1:DATA_WIDTH];
      end
   endgenerate

   // Pattern register file. Cleared on reset; written only by accepted writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            pat_regs[i] <= '0;
         end
      end else if (wr_accept) begin
         pat_regs[si_addr_i[IDX_W-1:0]] <= ctl_pat_data_i[DATA_WIDTH-1:0];
      end
   end

   // Next-state logic. The output word is computed here one cycle ahead so
   // pat_data_o can be a plain register that holds while the consumer stalls.
   // On start, a write to word 0 in the same cycle is forwarded so the first
   // beat shows the freshly written value. Dropping the enable in RUN lets the
   // presented beat complete and then ends the run, whatever the pointer.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      len_next   = len_q;
      loop_next  = loop_q;
      data_next  = pat_data_o;
      case (state)
         IDLE: begin
            data_next = '0;
            if (cfg_pat_gen_i && len_ok) begin
               state_next = RUN;
               ptr_next   = '0;
               len_next   = cfg_len_i;
               loop_next  = cfg_loop_i;
               if (wr_accept && (si_addr_i == '0)) begin
                  data_next = ctl_pat_data_i[DATA_WIDTH-1:0];
               end else begin
                  data_next = pat_regs[0];
               end
            end
         end
         RUN: begin
            if (beat) begin
               if (!cfg_pat_gen_i) begin
                  state_next = DONE;
                  data_next  = '0;
               end else if (!last_word) begin
                  ptr_next  = ptr + IDX_W'(1);
                  data_next = pat_regs[ptr + IDX_W'(1)];
               end else if (loop_q) begin
                  ptr_next  = '0;
                  data_next = pat_regs[0];
               end else begin
                  state_next = DONE;
                  data_next  = '0;
               end
            end
         end
         DONE: begin
            data_next = '0;
            if (!cfg_pat_gen_i) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            data_next  = '0;
         end
      endcase
   end

   // State, sequencing and registered outputs. Status outputs are decoded
   // from the next state so they line up with the state they describe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         ptr         <= '0;
         len_q       <= '0;
         loop_q      <= 1'b0;
         pat_data_o  <= '0;
         pat_valid_o <= 1'b0;
         nopg_o      <= 1'b1;
         done_o      <= 1'b0;
         wr_err_o    <= 1'b0;
      end else begin
         state       <= state_next;
         ptr         <= ptr_next;
         len_q       <= len_next;
         loop_q      <= loop_next;
         pat_data_o  <= data_next;
         pat_valid_o <= (state_next == RUN);
         nopg_o      <= (state_next != RUN);
         done_o      <= (state == RUN) && (state_next == DONE);
         wr_err_o    <= wr_drop;
      end
   end

`ifdef PAT_GEN_CHECKSUM_EN
   // Running XOR of accepted words, restarted on each new run and held
   // after the run ends so the consumer can read it in DONE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pat_csum_o <= '0;
      end else if (starting) begin
         pat_csum_o <= '0;
      end else if (beat) begin
         pat_csum_o <= pat_csum_o ^ pat_data_o;
      end
   end
`else
   // Start detection is only consumed by the checksum.
   logic unused_starting;
   assign unused_starting = starting;
`endif

endmodule

// File: tb/tb_pat_gen_seq.sv
// -----------------------------------------------------------------------------
// tb_pat_gen_seq
// -----------------------------------------------------------------------------
// Directed self-checking bench for pat_gen_seq with default parameters
// (ADDR_WIDTH=32, DATA_WIDTH=12, NUM_REGS=21). Each scenario task drives its
// own stimulus and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pat_gen_seq;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 12;
   localparam int NUM_REGS   = 21;
   localparam int SUB_W      = 32;
   localparam int IDX_W      = 5;

   logic                  clk_i;
   logic                  rst_i;
   logic [SUB_W-1:0]      ctl_pat_data_i;
   logic [ADDR_WIDTH-1:0] si_addr_i;
   logic                  wr_en_i;
   logic                  wr_err_o;
   logic                  cfg_pat_gen_i;
   logic [IDX_W-1:0]      cfg_len_i;
   logic                  cfg_loop_i;
   logic [DATA_WIDTH-1:0] pat_data_o;
   logic                  pat_valid_o;
   logic                  pat_ready_i;
   logic                  done_o;
   logic                  nopg_o;
`ifdef PAT_GEN_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] pat_csum_o;
`endif

   int checks;
   int fails;

   pat_gen_seq dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .ctl_pat_data_i (ctl_pat_data_i),
      .si_addr_i      (si_addr_i),
      .wr_en_i        (wr_en_i),
      .wr_err_o       (wr_err_o),
      .cfg_pat_gen_i  (cfg_pat_gen_i),
      .cfg_len_i      (cfg_len_i),
      .cfg_loop_i     (cfg_loop_i),
      .pat_data_o     (pat_data_o),
      .pat_valid_o    (pat_valid_o),
      .pat_ready_i    (pat_ready_i),
      .done_o         (done_o),
      .nopg_o         (nopg_o)
`ifdef PAT_GEN_CHECKSUM_EN
      ,
      .pat_csum_o     (pat_csum_o)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Single write cycle on the address/data port.
   task automatic write_word(input logic [ADDR_WIDTH-1:0] addr, input logic [SUB_W-1:0] data);
      wr_en_i        = 1'b1;
      si_addr_i      = addr;
      ctl_pat_data_i = data;
      step();
      wr_en_i        = 1'b0;
   endtask

   // Leave DONE and return to IDLE.
   task automatic finish_run();
      cfg_pat_gen_i = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      step();
      step();
      checks++;
      if (pat_valid_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_valid: got %b expected 0", pat_valid_o);
      end
      checks++;
      if (nopg_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_nopg: got %b expected 1", nopg_o);
      end
      checks++;
      if (pat_data_o !== 12'h000) begin
         fails++;
         $display("[TB] FAIL reset_data: got %h expected 000", pat_data_o);
      end
      checks++;
      if (done_o !== 1'b0 || wr_err_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_pulses: got done=%b wr_err=%b expected 0 0", done_o, wr_err_o);
      end
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_oneshot();
      logic [DATA_WIDTH-1:0] exp_words [3];
      exp_words[0] = 12'h111;
      exp_words[1] = 12'h222;
      exp_words[2] = 12'h333;
      for (int i = 0; i < 3; i++) begin
         write_word(ADDR_WIDTH'(i), SUB_W'(exp_words[i]));
         checks++;
         if (wr_err_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL oneshot_wr_ok %0d: got wr_err=%b expected 0", i, wr_err_o);
         end
      end
      cfg_len_i     = 5'd3;
      cfg_loop_i    = 1'b0;
      pat_ready_i   = 1'b1;
      cfg_pat_gen_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (pat_valid_o !== 1'b1 || nopg_o !== 1'b0 || pat_data_o !== exp_words[i]) begin
            fails++;
            $display("[TB] FAIL oneshot_beat %0d: got valid=%b nopg=%b data=%h expected 1 0 %h",
                     i, pat_valid_o, nopg_o, pat_data_o, exp_words[i]);
         end
      end
      step();
      checks++;
      if (pat_valid_o !== 1'b0 || done_o !== 1'b1 || nopg_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL oneshot_done: got valid=%b done=%b nopg=%b expected 0 1 1",
                  pat_valid_o, done_o, nopg_o);
      end
      step();
      checks++;
      if (done_o !== 1'b0 || pat_valid_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL oneshot_no_retrigger: got done=%b valid=%b expected 0 0", done_o, pat_valid_o);
      end
      finish_run();
   endtask

   task automatic test_bad_writes();
      logic [DATA_WIDTH-1:0] exp_words [3];
      exp_words[0] = 12'h111;
      exp_words[1] = 12'h222;
      exp_words[2] = 12'h333;
      write_word(32'd21, 32'h0000_0999);
      checks++;
      if (wr_err_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL bad_addr_21: got wr_err=%b expected 1", wr_err_o);
      end
      step();
      checks++;
      if (wr_err_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL wr_err_pulse: got wr_err=%b expected 0", wr_err_o);
      end
      write_word(32'h8000_0000, 32'h0000_0999);
      checks++;
      if (wr_err_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL bad_addr_msb: got wr_err=%b expected 1", wr_err_o);
      end
      cfg_len_i     = 5'd3;
      cfg_loop_i    = 1'b0;
      cfg_pat_gen_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (pat_data_o !== exp_words[i]) begin
            fails++;
            $display("[TB] FAIL bad_write_readback %0d: got %h expected %h", i, pat_data_o, exp_words[i]);
         end
      end
      step();
      finish_run();
   endtask

   task automatic test_truncate();
      write_word(32'd3, 32'h000A_BCDE);
      cfg_len_i     = 5'd4;
      cfg_loop_i    = 1'b0;
      cfg_pat_gen_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
      end
      checks++;
      if (pat_valid_o !== 1'b1 || pat_data_o !== 12'hCDE) begin
         fails++;
         $display("[TB] FAIL truncate_word: got valid=%b data=%h expected 1 cde", pat_valid_o, pat_data_o);
      end
      step();
      finish_run();
   endtask

   task automatic test_loop_abort();
      logic [DATA_WIDTH-1:0] exp_word;
      cfg_len_i     = 5'd2;
      cfg_loop_i    = 1'b1;
      pat_ready_i   = 1'b1;
      cfg_pat_gen_i = 1'b1;
      step();
      for (int i = 0; i < 7; i++) begin
         exp_word = (i % 2 == 0) ? 12'h111 : 12'h222;
         checks++;
         if (pat_valid_o !== 1'b1 || pat_data_o !== exp_word) begin
            fails++;
            $display("[TB] FAIL loop_beat %0d: got valid=%b data=%h expected 1 %h",
                     i, pat_valid_o, pat_data_o, exp_word);
         end
         if (i < 6) step();
      end
      pat_ready_i   = 1'b0;
      cfg_pat_gen_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (pat_valid_o !== 1'b1 || pat_data_o !== 12'h111 || done_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_hold %0d: got valid=%b data=%h done=%b expected 1 111 0",
                     i, pat_valid_o, pat_data_o, done_o);
         end
      end
      pat_ready_i = 1'b1;
      step();
      checks++;
      if (pat_valid_o !== 1'b0 || done_o !== 1'b1 || nopg_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL abort_done: got valid=%b done=%b nopg=%b expected 0 1 1",
                  pat_valid_o, done_o, nopg_o);
      end
      step();
      step();
   endtask

   task automatic test_invalid_len();
      logic [IDX_W-1:0] bad_lens [2];
      bad_lens[0] = 5'd0;
      bad_lens[1] = 5'd22;
      for (int k = 0; k < 2; k++) begin
         cfg_len_i     = bad_lens[k];
         cfg_loop_i    = 1'b0;
         cfg_pat_gen_i = 1'b1;
         step();
         step();
         step();
         checks++;
         if (pat_valid_o !== 1'b0 || nopg_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL invalid_len %0d: got valid=%b nopg=%b expected 0 1",
                     bad_lens[k], pat_valid_o, nopg_o);
         end
         cfg_pat_gen_i = 1'b0;
         step();
      end
   endtask

   task automatic test_write_during_run();
      cfg_len_i     = 5'd3;
      cfg_loop_i    = 1'b0;
      pat_ready_i   = 1'b1;
      cfg_pat_gen_i = 1'b1;
      step();
      write_word(32'd1, 32'h0000_0777);
      checks++;
      if (wr_err_o !== 1'b1 || pat_data_o !== 12'h222) begin
         fails++;
         $display("[TB] FAIL run_write: got wr_err=%b data=%h expected 1 222", wr_err_o, pat_data_o);
      end
      step();
      checks++;
      if (pat_data_o !== 12'h333 || wr_err_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL run_write_next: got data=%h wr_err=%b expected 333 0", pat_data_o, wr_err_o);
      end
      step();
      finish_run();
      cfg_len_i     = 5'd2;
      cfg_pat_gen_i = 1'b1;
      step();
      step();
      checks++;
      if (pat_data_o !== 12'h222) begin
         fails++;
         $display("[TB] FAIL run_write_readback: got %h expected 222", pat_data_o);
      end
      step();
      finish_run();
   endtask

   task automatic test_same_cycle_start();
      cfg_len_i     = 5'd1;
      cfg_loop_i    = 1'b0;
      pat_ready_i   = 1'b1;
      cfg_pat_gen_i = 1'b1;
      write_word(32'd0, 32'h0000_05A5);
      checks++;
      if (pat_valid_o !== 1'b1 || pat_data_o !== 12'h5A5 || wr_err_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL same_cycle_start: got valid=%b data=%h wr_err=%b expected 1 5a5 0",
                  pat_valid_o, pat_data_o, wr_err_o);
      end
      step();
      checks++;
      if (done_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL len1_done: got done=%b expected 1", done_o);
      end
      finish_run();
   endtask

   task automatic test_reset_mid_run();
      cfg_len_i     = 5'd3;
      cfg_loop_i    = 1'b1;
      pat_ready_i   = 1'b0;
      cfg_pat_gen_i = 1'b1;
      step();
      rst_i = 1'b1;
      step();
      checks++;
      if (pat_valid_o !== 1'b0 || nopg_o !== 1'b1 || pat_data_o !== 12'h000) begin
         fails++;
         $display("[TB] FAIL reset_mid_run: got valid=%b nopg=%b data=%h expected 0 1 000",
                  pat_valid_o, nopg_o, pat_data_o);
      end
      rst_i         = 1'b0;
      cfg_pat_gen_i = 1'b0;
      step();
      cfg_loop_i    = 1'b0;
      pat_ready_i   = 1'b1;
      cfg_pat_gen_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (pat_valid_o !== 1'b1 || pat_data_o !== 12'h000) begin
            fails++;
            $display("[TB] FAIL regs_cleared %0d: got valid=%b data=%h expected 1 000",
                     i, pat_valid_o, pat_data_o);
         end
      end
      step();
      finish_run();
   endtask

`ifdef PAT_GEN_CHECKSUM_EN
   task automatic test_checksum();
      write_word(32'd0, 32'h0000_0111);
      write_word(32'd1, 32'h0000_0222);
      write_word(32'd2, 32'h0000_0333);
      cfg_len_i     = 5'd3;
      cfg_loop_i    = 1'b0;
      pat_ready_i   = 1'b1;
      cfg_pat_gen_i = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (pat_csum_o !== 12'h000) begin
         fails++;
         $display("[TB] FAIL csum_len3: got %h expected 000", pat_csum_o);
      end
      finish_run();
      cfg_len_i     = 5'd2;
      cfg_pat_gen_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (pat_csum_o !== 12'h333) begin
         fails++;
         $display("[TB] FAIL csum_len2: got %h expected 333", pat_csum_o);
      end
      finish_run();
   endtask
`endif

   // Scenario sequence.
   initial begin
      checks         = 0;
      fails          = 0;
      rst_i          = 1'b1;
      ctl_pat_data_i = '0;
      si_addr_i      = '0;
      wr_en_i        = 1'b0;
      cfg_pat_gen_i  = 1'b0;
      cfg_len_i      = '0;
      cfg_loop_i     = 1'b0;
      pat_ready_i    = 1'b0;
      test_reset();
      test_oneshot();
      test_bad_writes();
      test_truncate();
      test_loop_abort();
      test_invalid_len();
      test_write_during_run();
      test_same_cycle_start();
      test_reset_mid_run();
`ifdef PAT_GEN_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
